// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with guard gaps,
// leading-zero blanking and frame-aligned (tear-free) display updates.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  dig_sel,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        upd_pend,
  output logic        frame_done
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    GRD_MAX = 8'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_SHOW,
    S_GUARD
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_gcnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_dpsh;
  logic [15:0]   r_pend;
  logic [3:0]    r_dppend;
  logic          r_upd;
  logic          r_fd;
  logic [3:0]    r_an;
  logic          r_dpn;
  logic [3:0]    r_dig;

  state_t        w_state_n;
  logic [PW-1:0] w_pre_n;
  logic [7:0]    w_gcnt_n;
  logic [1:0]    w_idx_n;
  logic          w_xfer;
  logic          w_wrap;
  logic [15:0]   w_shadow_n;
  logic [3:0]    w_dpsh_n;
  logic [3:0]    w_digit;
  logic          w_z3;
  logic          w_z2;
  logic          w_z1;
  logic          w_blank;
  logic          w_show;
  logic [3:0]    w_an_oh;

  always_comb begin
    w_state_n = r_state;
    w_pre_n   = r_pre;
    w_gcnt_n  = r_gcnt;
    w_idx_n   = r_idx;
    w_xfer    = 1'b0;
    w_wrap    = 1'b0;
    if (!en) begin
      w_state_n = S_OFF;
      w_pre_n   = '0;
      w_gcnt_n  = '0;
      w_idx_n   = '0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          w_state_n = S_SHOW;
          w_pre_n   = '0;
          w_gcnt_n  = '0;
          w_idx_n   = '0;
          w_xfer    = r_upd;
        end
        S_SHOW: begin
          if (r_pre == PRE_MAX) begin
            w_state_n = S_GUARD;
            w_pre_n   = '0;
            w_gcnt_n  = '0;
          end else begin
            w_pre_n = r_pre + 1'b1;
          end
        end
        S_GUARD: begin
          if (r_gcnt == GRD_MAX) begin
            w_state_n = S_SHOW;
            w_gcnt_n  = '0;
            w_idx_n   = r_idx + 2'd1;
            w_wrap    = (r_idx == 2'd3);
            w_xfer    = (r_idx == 2'd3) && r_upd;
          end else begin
            w_gcnt_n = r_gcnt + 8'd1;
          end
        end
        default: begin
          w_state_n = S_OFF;
          w_pre_n   = '0;
          w_gcnt_n  = '0;
          w_idx_n   = '0;
        end
      endcase
    end
  end

  // outputs are registered from next-state values so they align with state
  assign w_shadow_n = w_xfer ? r_pend : r_shadow;
  assign w_dpsh_n   = w_xfer ? r_dppend : r_dpsh;
  assign w_digit    = w_shadow_n[{w_idx_n, 2'b00} +: 4];
  assign w_z3       = (w_shadow_n[15:12] == 4'h0);
  assign w_z2       = (w_shadow_n[11:8] == 4'h0);
  assign w_z1       = (w_shadow_n[7:4] == 4'h0);

  always_comb begin
    w_blank = 1'b0;
    unique case (w_idx_n)
      2'd3:    w_blank = blank_lz & w_z3;
      2'd2:    w_blank = blank_lz & w_z3 & w_z2;
      2'd1:    w_blank = blank_lz & w_z3 & w_z2 & w_z1;
      default: w_blank = 1'b0;
    endcase
  end

  assign w_show  = (w_state_n == S_SHOW) && !w_blank;
  assign w_an_oh = 4'b0001 << w_idx_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_OFF;
      r_pre    <= '0;
      r_gcnt   <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_dpsh   <= '0;
      r_pend   <= '0;
      r_dppend <= '0;
      r_upd    <= 1'b0;
      r_fd     <= 1'b0;
      r_an     <= 4'hF;
      r_dpn    <= 1'b1;
      r_dig    <= 4'h0;
    end else begin
      r_state  <= w_state_n;
      r_pre    <= w_pre_n;
      r_gcnt   <= w_gcnt_n;
      r_idx    <= w_idx_n;
      r_shadow <= w_shadow_n;
      r_dpsh   <= w_dpsh_n;
      if (load) begin
        r_pend   <= digits_in;
        r_dppend <= dp_in;
        r_upd    <= 1'b1;
      end else if (w_xfer) begin
        r_upd <= 1'b0;
      end
      r_fd  <= w_wrap;
      r_dig <= w_digit;
      r_an  <= w_show ? ~w_an_oh : 4'hF;
      r_dpn <= w_show ? ~w_dpsh_n[w_idx_n] : 1'b1;
    end
  end

  assign dig_sel    = r_dig;
  assign an         = r_an;
  assign dp_n       = r_dpn;
  assign upd_pend   = r_upd;
  assign frame_done = r_fd;

endmodule
